// File: rtl/sorter_pkg.sv
// rtl/sorter_pkg.sv - shared sorter types: drain slot record and drain FSM states
package sorter_pkg;

    localparam int SORT_DATAWIDTH  = 8;
    localparam int SORT_DATALENGTH = 16;
    localparam int SORT_KW         = $clog2(SORT_DATALENGTH + 1);

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } drain_state_e;

    typedef struct packed {
        logic [SORT_DATALENGTH-1:0][SORT_DATAWIDTH-1:0] data;
        logic                                           desc;
        logic [SORT_KW-1:0]                             k;
    } drain_slot_t;

endpackage

// File: rtl/bitonic_drain_sel.sv
// rtl/bitonic_drain_sel.sv - picks the element of a sorted vector holding a given rank
module bitonic_drain_sel
    import sorter_pkg::*;
#(
    parameter int DATAWIDTH  = SORT_DATAWIDTH,
    parameter int DATALENGTH = SORT_DATALENGTH,
    parameter int IW         = $clog2(DATALENGTH)
) (
    input  logic [DATALENGTH-1:0][DATAWIDTH-1:0] data_i,
    input  logic [IW-1:0]                        rank_i,
    input  logic                                 desc_i,
    output logic [DATAWIDTH-1:0]                 data_o
);

    logic [IW-1:0] idx;

    // DATALENGTH is a power of two, so DATALENGTH-1-rank is just ~rank.
    always_comb begin
        idx    = desc_i ? rank_i : ~rank_i;
        data_o = data_i[idx];
    end

endmodule

// File: rtl/bitonic_16_drain.sv
// rtl/bitonic_16_drain.sv - ping-pong buffer that streams top-k of sorted vectors, largest first
module bitonic_16_drain
    import sorter_pkg::*;
#(
    parameter int DATAWIDTH  = SORT_DATAWIDTH,
    parameter int DATALENGTH = SORT_DATALENGTH,
    parameter int KW         = $clog2(DATALENGTH + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [DATAWIDTH-1:0] in_data_i [DATALENGTH],
    input  logic                 in_desc_i,
    input  logic [KW-1:0]        in_k_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [DATAWIDTH-1:0] out_data_o,
    output logic [KW-1:0]        out_rank_o,
    output logic                 out_last_o,
    output logic                 overflow_o,
    output logic                 busy_o
);

    localparam int IW = $clog2(DATALENGTH);

    drain_state_e   state_q, state_d;
    logic [KW-1:0]  rank_q, rank_d;
    logic           wr_ptr_q, rd_ptr_q;
    logic [1:0]     vld_q, vld_d;
    logic           overflow_q;
    drain_slot_t    slot_q [2];
    drain_slot_t    wr_slot;
    drain_slot_t    head;
    logic           accept, fire, free, last;
    logic [DATAWIDTH-1:0] sel_data;

    always_comb begin
        wr_slot      = '0;
        for (int i = 0; i < DATALENGTH; i++) begin
            wr_slot.data[i] = in_data_i[i];
        end
        wr_slot.desc = in_desc_i;
        wr_slot.k    = (in_k_i > KW'(DATALENGTH)) ? KW'(DATALENGTH) : in_k_i;
    end

    assign head        = slot_q[rd_ptr_q];
    assign in_ready_o  = ~&vld_q;
    assign busy_o      = |vld_q;
    assign overflow_o  = overflow_q;
    assign out_valid_o = (state_q == STREAM);
    assign accept      = in_valid_i && in_ready_o;
    assign fire        = out_valid_o && out_ready_i;
    assign last        = out_valid_o && (rank_q == head.k - KW'(1));
    assign out_last_o  = last;
    assign out_rank_o  = out_valid_o ? rank_q : '0;
    assign out_data_o  = out_valid_o ? sel_data : '0;

    bitonic_drain_sel #(
        .DATAWIDTH  (DATAWIDTH),
        .DATALENGTH (DATALENGTH),
        .IW         (IW)
    ) u_sel (
        .data_i (head.data),
        .rank_i (rank_q[IW-1:0]),
        .desc_i (head.desc),
        .data_o (sel_data)
    );

    always_comb begin
        state_d = state_q;
        rank_d  = rank_q;
        free    = 1'b0;
        case (state_q)
            IDLE: begin
                if (vld_q[rd_ptr_q]) begin
                    if (head.k != '0) begin
                        state_d = STREAM;
                        rank_d  = '0;
                    end else begin
                        free = 1'b1;
                    end
                end else if (accept && wr_slot.k != '0) begin
                    // Empty store: the write lands at rd_ptr, so start streaming on the same edge.
                    state_d = STREAM;
                    rank_d  = '0;
                end
            end
            STREAM: begin
                if (fire) begin
                    rank_d = rank_q + KW'(1);
                    if (last) begin
                        free = 1'b1;
                        if (vld_q[~rd_ptr_q] && slot_q[~rd_ptr_q].k != '0) begin
                            rank_d = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        vld_d = vld_q;
        if (free) begin
            vld_d[rd_ptr_q] = 1'b0;
        end
        if (accept) begin
            vld_d[wr_ptr_q] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            rank_q     <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            vld_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rank_q   <= rank_d;
            vld_q    <= vld_d;
            if (accept) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (free) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            if (in_valid_i && !in_ready_o) begin
                overflow_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept) begin
            slot_q[wr_ptr_q] <= wr_slot;
        end
    end

endmodule

// File: tb/tb_bitonic_16_drain.sv
// tb/tb_bitonic_16_drain.sv - scoreboard bench for bitonic_16_drain
module tb_bitonic_16_drain;

    localparam int W  = 8;
    localparam int N  = 16;
    localparam int KW = 5;

    logic          clk = 1'b0;
    logic          rst_i = 1'b1;
    logic          in_valid_i = 1'b0;
    logic          in_ready_o;
    logic [W-1:0]  in_data_i [N];
    logic          in_desc_i = 1'b0;
    logic [KW-1:0] in_k_i = '0;
    logic          out_valid_o;
    logic          out_ready_i = 1'b0;
    logic [W-1:0]  out_data_o;
    logic [KW-1:0] out_rank_o;
    logic          out_last_o;
    logic          overflow_o;
    logic          busy_o;

    always #5 clk = ~clk;

    bitonic_16_drain #(.DATAWIDTH(W), .DATALENGTH(N), .KW(KW)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (in_data_i),
        .in_desc_i   (in_desc_i),
        .in_k_i      (in_k_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o),
        .out_rank_o  (out_rank_o),
        .out_last_o  (out_last_o),
        .overflow_o  (overflow_o),
        .busy_o      (busy_o)
    );

    typedef struct {
        logic [W-1:0]  data;
        logic [KW-1:0] rank;
        logic          last;
    } beat_t;

    beat_t exp_q[$];
    int    errors = 0;
    int    checks = 0;
    int    fires  = 0;

    logic          s_valid, s_ready, s_busy, s_ovf, s_last;
    logic [W-1:0]  s_data;
    logic [KW-1:0] s_rank;
    logic          stalled = 1'b0;
    logic [W-1:0]  h_data;
    logic [KW-1:0] h_rank;
    logic          h_last;

    task automatic monitor();
        beat_t e;
        s_valid = out_valid_o;
        s_ready = in_ready_o;
        s_busy  = busy_o;
        s_ovf   = overflow_o;
        s_data  = out_data_o;
        s_rank  = out_rank_o;
        s_last  = out_last_o;
        if (rst_i) begin
            stalled = 1'b0;
            return;
        end
        if (stalled) begin
            checks++;
            if (out_valid_o !== 1'b1 || out_data_o !== h_data || out_rank_o !== h_rank || out_last_o !== h_last) begin
                errors++;
                $display("FAIL stall_hold: got v=%0b d=%0d r=%0d l=%0b, want v=1 d=%0d r=%0d l=%0b",
                         out_valid_o, out_data_o, out_rank_o, out_last_o, h_data, h_rank, h_last);
            end
        end
        if (out_valid_o === 1'b1 && out_ready_i) begin
            fires++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_beat: got d=%0d r=%0d, want no beat", out_data_o, out_rank_o);
            end else begin
                e = exp_q.pop_front();
                if (out_data_o !== e.data || out_rank_o !== e.rank || out_last_o !== e.last) begin
                    errors++;
                    $display("FAIL beat: got d=%0d r=%0d l=%0b, want d=%0d r=%0d l=%0b",
                             out_data_o, out_rank_o, out_last_o, e.data, e.rank, e.last);
                end
            end
        end
        stalled = (out_valid_o === 1'b1) && !out_ready_i;
        h_data  = out_data_o;
        h_rank  = out_rank_o;
        h_last  = out_last_o;
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_vec(input int base, input int step, input logic desc, input int k, input bit accepted);
        int kcap;
        int idx;
        beat_t b;
        for (int i = 0; i < N; i++) begin
            in_data_i[i] = 8'(base + step * i);
        end
        in_desc_i  = desc;
        in_k_i     = 5'(k);
        in_valid_i = 1'b1;
        kcap = (k > N) ? N : k;
        if (accepted) begin
            for (int r = 0; r < kcap; r++) begin
                idx    = desc ? r : (N - 1 - r);
                b.data = 8'(base + step * idx);
                b.rank = 5'(r);
                b.last = (r == kcap - 1);
                exp_q.push_back(b);
            end
        end
    endtask

    task automatic drain(input int budget, input string name);
        int n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: got %0d beats outstanding, want 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
        tick();
        checks += 7;
        if (s_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b want 0", s_valid); end
        if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b want 1", s_ready); end
        if (s_busy  !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", s_busy); end
        if (s_ovf   !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %0b want 0", s_ovf); end
        if (s_data  !== '0)   begin errors++; $display("FAIL reset_out_data: got %0d want 0", s_data); end
        if (s_rank  !== '0)   begin errors++; $display("FAIL reset_out_rank: got %0d want 0", s_rank); end
        if (s_last  !== 1'b0) begin errors++; $display("FAIL reset_out_last: got %0b want 0", s_last); end
    endtask

    task automatic test_ascending();
        out_ready_i = 1'b1;
        drive_vec(0, 1, 1'b0, 4, 1'b1);
        tick();
        in_valid_i = 1'b0;
        tick();
        checks++;
        if (s_valid !== 1'b1) begin errors++; $display("FAIL asc_latency: got out_valid=%0b want 1", s_valid); end
        drain(50, "asc");
        tick();
        checks += 2;
        if (s_valid !== 1'b0) begin errors++; $display("FAIL asc_idle: got out_valid=%0b want 0", s_valid); end
        if (s_busy  !== 1'b0) begin errors++; $display("FAIL asc_busy: got %0b want 0", s_busy); end
    endtask

    task automatic test_desc_clamp();
        out_ready_i = 1'b1;
        drive_vec(15, -1, 1'b1, 20, 1'b1);
        tick();
        in_valid_i = 1'b0;
        drain(60, "desc_clamp");
        tick();
    endtask

    task automatic test_overflow_back_to_back();
        int gap = 0;
        int n = 0;
        out_ready_i = 1'b0;
        drive_vec(100, 1, 1'b0, 3, 1'b1);
        tick();
        drive_vec(50, 3, 1'b1, 5, 1'b1);
        tick();
        drive_vec(200, 1, 1'b0, 4, 1'b0);
        tick();
        checks++;
        if (s_ready !== 1'b0) begin errors++; $display("FAIL ovf_in_ready: got %0b want 0", s_ready); end
        in_valid_i = 1'b0;
        tick();
        checks += 2;
        if (s_ovf  !== 1'b1) begin errors++; $display("FAIL ovf_set: got %0b want 1", s_ovf); end
        if (s_busy !== 1'b1) begin errors++; $display("FAIL ovf_busy: got %0b want 1", s_busy); end
        out_ready_i = 1'b1;
        while (exp_q.size() > 0 && n < 40) begin
            tick();
            n++;
            if (s_valid !== 1'b1) gap++;
        end
        checks++;
        if (gap != 0) begin errors++; $display("FAIL b2b_gap: got %0d idle cycles want 0", gap); end
        drain(5, "b2b");
        tick();
        checks++;
        if (s_ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %0b want 1", s_ovf); end
    endtask

    task automatic test_k_zero();
        out_ready_i = 1'b1;
        drive_vec(7, 2, 1'b0, 0, 1'b1);
        tick();
        drive_vec(9, 5, 1'b1, 2, 1'b1);
        tick();
        in_valid_i = 1'b0;
        drain(30, "k_zero");
        tick();
        checks += 2;
        if (s_busy  !== 1'b0) begin errors++; $display("FAIL kzero_busy: got %0b want 0", s_busy); end
        if (s_valid !== 1'b0) begin errors++; $display("FAIL kzero_idle: got out_valid=%0b want 0", s_valid); end
    endtask

    task automatic test_random_stall();
        int f0 = fires;
        int n = 0;
        out_ready_i = 1'b0;
        drive_vec(30, 7, 1'b0, 8, 1'b1);
        tick();
        in_valid_i = 1'b0;
        while (exp_q.size() > 0 && n < 200) begin
            out_ready_i = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        out_ready_i = 1'b1;
        drain(5, "stall");
        checks++;
        if (fires - f0 != 8) begin errors++; $display("FAIL stall_count: got %0d transfers want 8", fires - f0); end
        tick();
    endtask

    task automatic test_reset_midstream();
        int n = 0;
        bit found = 1'b0;
        out_ready_i = 1'b1;
        drive_vec(60, 1, 1'b1, 8, 1'b1);
        tick();
        in_valid_i = 1'b0;
        while (!found && n < 20) begin
            tick();
            n++;
            if (s_valid === 1'b1 && s_rank == 5'd3) found = 1'b1;
        end
        checks++;
        if (!found) begin errors++; $display("FAIL mid_rank3: got no rank-3 beat, want one"); end
        rst_i = 1'b1;
        exp_q.delete();
        tick();
        rst_i = 1'b0;
        tick();
        checks += 4;
        if (s_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid: got %0b want 0", s_valid); end
        if (s_busy  !== 1'b0) begin errors++; $display("FAIL mid_busy: got %0b want 0", s_busy); end
        if (s_ovf   !== 1'b0) begin errors++; $display("FAIL mid_overflow: got %0b want 0", s_ovf); end
        if (s_ready !== 1'b1) begin errors++; $display("FAIL mid_in_ready: got %0b want 1", s_ready); end
        drive_vec(80, 2, 1'b1, 3, 1'b1);
        tick();
        in_valid_i = 1'b0;
        tick();
        checks++;
        if (s_valid !== 1'b1 || s_rank !== 5'd0) begin
            errors++;
            $display("FAIL mid_restart: got v=%0b r=%0d want v=1 r=0", s_valid, s_rank);
        end
        drain(30, "mid_restart");
    endtask

    initial begin
        for (int i = 0; i < N; i++) in_data_i[i] = '0;
        test_reset();
        test_ascending();
        test_desc_clamp();
        test_overflow_back_to_back();
        test_k_zero();
        test_random_stall();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
